// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle for the nibble-serial adder: the requester drives
// operands and start, the adder returns busy/done and the registered result.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] SUM;
  logic             Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, SUM, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, SUM, Cout
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one 4-bit carry-look-ahead slice over
// WIDTH/4 clocks, LSB nibble first, with a registered inter-nibble carry.

module cla4_slice (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] SUM,
  output logic       Cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = A ^ B;
  assign g = A & B;

  // Every carry is expanded directly from generate/propagate terms.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign Cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign SUM = p ^ c;
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             done_reg;

  logic             load;
  logic             step;
  logic             finish;
  logic             busy;

  logic [3:0]       a_sel;
  logic [3:0]       b_sel;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    busy   = 1'b0;
    case (state_reg)
      IDLE: load = bus.start;
      RUN: begin
        busy   = 1'b1;
        step   = 1'b1;
        finish = (cnt_reg == LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    a_sel = 4'h0;
    b_sel = 4'h0;
    for (int i = 0; i < N; i++) begin
      if (cnt_reg == CW'(i)) begin
        a_sel = opa_reg[i*4 +: 4];
        b_sel = opb_reg[i*4 +: 4];
      end
    end
  end

  cla4_slice u_slice (
    .A    (a_sel),
    .B    (b_sel),
    .Cin  (carry_reg),
    .SUM  (slice_sum),
    .Cout (slice_cout)
  );

  // Partial sum with the current nibble merged in; on the last nibble this is the full result.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_acc
      assign acc_next[gi*4 +: 4] = (cnt_reg == CW'(gi)) ? slice_sum : acc_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        opa_reg   <= bus.A;
        opb_reg   <= bus.B;
        carry_reg <= bus.Cin;
        cnt_reg   <= '0;
        acc_reg   <= '0;
      end
      if (step) begin
        acc_reg   <= acc_next;
        carry_reg <= slice_cout;
        cnt_reg   <= cnt_reg + 1'b1;
      end
      if (finish) begin
        sum_reg  <= acc_next;
        cout_reg <= slice_cout;
        done_reg <= 1'b1;
        cnt_reg  <= '0;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_reg;
  assign bus.SUM  = sum_reg;
  assign bus.Cout = cout_reg;
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle N-bit adder built around the existing 4-bit gate-level carry-look-ahead slice (ports A, B, Cin, SUM, Cout). It accepts wide operands with a start pulse and feeds them to the slice one nibble per clock, LSB nibble first, registering the inter-nibble carry. It then presents the full-width sum and carry-out with a one-cycle done pulse. It sits directly upstream of the CLA slice and trades latency for area on wide datapaths.

## Interface

- WIDTH, 16, operand/sum width in bits. It must be a multiple of 4 and at least 4. N = WIDTH/4 nibbles.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only when busy=0.
- A  in  WIDTH  operand A. Captured on the accepting edge.
- B  in  WIDTH  operand B. Captured on the accepting edge.
- Cin  in  1  carry-in. Captured on the accepting edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when SUM/Cout take a new result.
- SUM  out  WIDTH  registered sum. Holds until the next completion.
- Cout  out  1  registered carry-out of the MSB nibble.

## Operation

- States: IDLE, RUN. The nibble counter is cnt (0..N-1). Internal registers are opA, opB, carry, and the accumulating partial sum acc.
- IDLE with start=1 at an edge:
  - opA<=A, opB<=B, carry<=Cin, cnt<=0, acc<=0.
  - busy<=1, state<=RUN.
- RUN, each edge:
  - The slice receives opA[4cnt+3:4cnt], opB[4cnt+3:4cnt] and carry.
  - The slice sum nibble is written to acc[4cnt+3:4cnt], and carry<=slice Cout.
  - cnt<=cnt+1.
- RUN with cnt=N-1:
  - SUM<=final acc including this nibble, Cout<=slice Cout.
  - done<=1, busy<=0, state<=IDLE.
- Arithmetic: {Cout,SUM} = A + B + Cin, modulo 2^(WIDTH+1) (exact, no overflow loss). Operands are unsigned.
- start while busy=1: ignored, not queued. Changes to A/B/Cin during RUN have no effect.
- done is high for exactly one cycle per accepted start and is never asserted without a preceding accept.
- SUM/Cout change only on the edge that raises done. Between operations they hold the last result.
- rst=1 at any edge, including mid-RUN:
  - state<=IDLE, busy<=0, done<=0, SUM<=0, Cout<=0, cnt<=0, carry<=0.
  - Any in-flight operation is aborted and produces no done.
  - rst has priority over start in the same cycle.
- The combinational slice is used exactly once per RUN cycle. No combinational path from the inputs to any output.

## Timing

- Accept edge t (IDLE, start=1): busy=1 from t.
- Nibble k is processed at edge t+1+k, for k=0..N-1.
- Completion edge t+N: SUM/Cout valid, done=1 and busy=0 for the cycle following t+N.
- Latency is N cycles from the accept edge to done. WIDTH=16 gives 4 cycles; WIDTH=4 gives 1 cycle.
- Earliest next accept is edge t+N+1: start held high during the done cycle is accepted. Back-to-back throughput is one result per N+1 cycles.
- Reset values: busy=0, done=0, SUM=0, Cout=0.

## Test plan

- Basic add (WIDTH=16): reset, then A=0x0001, B=0x0002, Cin=0, start pulse.
  - SUM=0x0003, Cout=0.
  - done exactly 4 cycles after accept, single-cycle.
  - busy high for 4 cycles.
- Full carry ripple: A=0xFFFF, B=0x0001, Cin=0 -> SUM=0x0000, Cout=1.
  - Also A=0xA5A5, B=0x5A5A, Cin=1 -> SUM=0x0000, Cout=1.
  - These confirm the carry crosses every nibble boundary.
- Busy protection: accept A=0x1234, B=0x1111, Cin=0. Then during RUN, drive start=1 with A=0xFFFF, B=0xFFFF.
  - Result SUM=0x2345, Cout=0.
  - Only one done pulse.
- Back-to-back: hold start=1 continuously across two different operand sets.
  - The second accept occurs on the edge after the first done.
  - Results are correct in order, 5-cycle spacing.
  - SUM holds the first result until the second done.
- Reset mid-operation: accept 0x8000+0x8000, assert rst at edge t+2.
  - busy=0, SUM=0, Cout=0, no done.
  - The next operation, 0x00FF+0x0001, Cin=1, gives SUM=0x0101, Cout=0.
- WIDTH=4 instance: A=0xF, B=0x1, Cin=1 -> SUM=0x1, Cout=1, with done 1 cycle after accept.
